// File: rtl/alex_relay_sequencer.sv
// Alex filter-board relay sequencer.
// Serialises relay words and keeps TX muted while relays move.
module alex_relay_sequencer #(
   parameter int CLK_DIV       = 4,
   parameter int MUTE_CYCLES   = 1228,
   parameter int LATCH_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 614400
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] lpf_req,
   input  logic [5:0] hpf_req,
   input  logic       ptt_in,
   output logic       SPI_data,
   output logic       SPI_clock,
   output logic       load_strobe,
   output logic       tx_inhibit,
   output logic       busy,
   output logic [6:0] lpf_active,
   output logic [5:0] hpf_active
);

   localparam int CW = 20;

   // Reload values are "count - 1" so each phase lasts exactly count cycles.
   localparam int DIV_M1 = (CLK_DIV > 0) ? CLK_DIV - 1 : 0;
   localparam int MUTE_M1 = (MUTE_CYCLES > 0) ? MUTE_CYCLES - 1 : 0;
   localparam int LATCH_M1 = (LATCH_CYCLES > 0) ? LATCH_CYCLES - 1 : 0;
   localparam int SETTLE_M1 = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

   localparam logic [CW-1:0] DIV_LD    = CW'(DIV_M1);
   localparam logic [CW-1:0] MUTE_LD   = CW'(MUTE_M1);
   localparam logic [CW-1:0] LATCH_LD  = CW'(LATCH_M1);
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_M1);

   typedef enum logic [2:0] {
      IDLE,
      MUTE,
      SHIFT,
      LATCH,
      SETTLE
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [CW-1:0] cnt_dec;
   logic [3:0]    bit_idx;
   logic [3:0]    bit_n;
   logic          phase;
   logic          phase_n;
   logic [13:0]   snap;
   logic [13:0]   snap_n;
   logic          force_load;
   logic          force_n;
   logic          pending;
   logic          pend_n;

   logic [6:0]    lpf_q;
   logic [5:0]    hpf_q;
   logic          ptt_q;
   logic [13:0]   req_q;
   logic          change;
   logic [15:0]   word_n;

   logic          spi_data_n;
   logic          spi_clock_n;
   logic          strobe_n;
   logic          tx_n;
   logic          busy_n;
   logic [6:0]    lpf_act_n;
   logic [5:0]    hpf_act_n;

   assign req_q   = {ptt_q, hpf_q, lpf_q};
   assign change  = (req_q != snap);
   assign cnt_dec = (cnt == '0) ? '0 : cnt - 1'b1;

   // Request capture; free-running so a forced load sees the live request.
   always_ff @(posedge clock) begin
      lpf_q <= lpf_req;
      hpf_q <= hpf_req;
      ptt_q <= ptt_in;
   end

   // Sequencer next-state, counters and registered-output values.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_n     = bit_idx;
      phase_n   = phase;
      snap_n    = snap;
      force_n   = force_load;
      pend_n    = pending;
      lpf_act_n = lpf_active;
      hpf_act_n = hpf_active;

      unique case (state)
         IDLE: begin
            if (change || force_load || pending) begin
               snap_n  = req_q;
               force_n = 1'b0;
               pend_n  = 1'b0;
               if (ptt_q || snap[13]) begin
                  state_n = MUTE;
                  cnt_n   = MUTE_LD;
               end else begin
                  state_n = SHIFT;
                  cnt_n   = DIV_LD;
                  bit_n   = 4'd15;
                  phase_n = 1'b0;
               end
            end
         end
         MUTE: begin
            if (cnt == '0) begin
               state_n = SHIFT;
               cnt_n   = DIV_LD;
               bit_n   = 4'd15;
               phase_n = 1'b0;
            end else begin
               cnt_n = cnt_dec;
            end
         end
         SHIFT: begin
            if (cnt != '0) begin
               cnt_n = cnt_dec;
            end else if (!phase) begin
               phase_n = 1'b1;
               cnt_n   = DIV_LD;
            end else if (bit_idx == 4'd0) begin
               state_n   = LATCH;
               cnt_n     = LATCH_LD;
               phase_n   = 1'b0;
               lpf_act_n = snap[6:0];
               hpf_act_n = snap[12:7];
            end else begin
               bit_n   = bit_idx - 4'd1;
               phase_n = 1'b0;
               cnt_n   = DIV_LD;
            end
         end
         LATCH: begin
            if (cnt == '0) begin
               state_n = SETTLE;
               cnt_n   = SETTLE_LD;
            end else begin
               cnt_n = cnt_dec;
            end
         end
         SETTLE: begin
            if (cnt == '0) begin
               state_n = IDLE;
            end else begin
               cnt_n = cnt_dec;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // A request that moves mid-sequence is replayed once we are back.
      if (state != IDLE && change) begin
         pend_n = 1'b1;
      end

      word_n      = {2'b00, snap_n};
      spi_clock_n = (state_n == SHIFT) && phase_n;
      spi_data_n  = (state_n == SHIFT) ? word_n[bit_n] : 1'b0;
      strobe_n    = (state_n == LATCH);
      busy_n      = (state_n != IDLE);
      tx_n        = (state_n != IDLE) || pend_n;
   end

   // Sequencer state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= 4'd0;
         phase      <= 1'b0;
         snap       <= '0;
         force_load <= 1'b1;
         pending    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_idx    <= bit_n;
         phase      <= phase_n;
         snap       <= snap_n;
         force_load <= force_n;
         pending    <= pend_n;
      end
   end

   // Glitch-free registered outputs to the Alex connector and TX chain.
   always_ff @(posedge clock) begin
      if (reset) begin
         SPI_data    <= 1'b0;
         SPI_clock   <= 1'b0;
         load_strobe <= 1'b0;
         tx_inhibit  <= 1'b1;
         busy        <= 1'b0;
         lpf_active  <= 7'd0;
         hpf_active  <= 6'd0;
      end else begin
         SPI_data    <= spi_data_n;
         SPI_clock   <= spi_clock_n;
         load_strobe <= strobe_n;
         tx_inhibit  <= tx_n;
         busy        <= busy_n;
         lpf_active  <= lpf_act_n;
         hpf_active  <= hpf_act_n;
      end
   end

endmodule

// File: tb/tb_alex_relay_sequencer.sv
// Scoreboard bench for alex_relay_sequencer.
// Two builds: CLK_DIV=2 main run, CLK_DIV=1 timing run.
module tb_alex_relay_sequencer;

   localparam int DIV  = 2;
   localparam int MUTE = 10;
   localparam int LAT  = 4;
   localparam int SET  = 40;
   localparam int SLEN = 32 * DIV;

   typedef struct {
      logic [15:0] word;
      bit          mute;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset;
   logic [6:0] lpf_req;
   logic [5:0] hpf_req;
   logic       ptt_in;
   logic       SPI_data, SPI_clock, load_strobe;
   logic       tx_inhibit, busy;
   logic [6:0] lpf_active;
   logic [5:0] hpf_active;

   logic       reset1;
   logic [6:0] lpf1;
   logic [5:0] hpf1;
   logic       ptt1;
   logic       data1, sclk1, load1, tx1, busy1;
   logic [6:0] lpfa1;
   logic [5:0] hpfa1;

   alex_relay_sequencer #(
      .CLK_DIV(DIV), .MUTE_CYCLES(MUTE),
      .LATCH_CYCLES(LAT), .SETTLE_CYCLES(SET)
   ) dut (
      .clock(clock), .reset(reset),
      .lpf_req(lpf_req), .hpf_req(hpf_req), .ptt_in(ptt_in),
      .SPI_data(SPI_data), .SPI_clock(SPI_clock),
      .load_strobe(load_strobe), .tx_inhibit(tx_inhibit),
      .busy(busy), .lpf_active(lpf_active), .hpf_active(hpf_active)
   );

   alex_relay_sequencer #(
      .CLK_DIV(1), .MUTE_CYCLES(MUTE),
      .LATCH_CYCLES(LAT), .SETTLE_CYCLES(SET)
   ) dut1 (
      .clock(clock), .reset(reset1),
      .lpf_req(lpf1), .hpf_req(hpf1), .ptt_in(ptt1),
      .SPI_data(data1), .SPI_clock(sclk1),
      .load_strobe(load1), .tx_inhibit(tx1),
      .busy(busy1), .lpf_active(lpfa1), .hpf_active(hpfa1)
   );

   int n_chk = 0;
   int n_fail = 0;
   exp_t sb[$];
   logic [15:0] sb1[$];
   bit last_ptt = 1'b0;
   int strobes = 0;
   int strobes1 = 0;
   int nbits = 0;
   bit done1 = 1'b0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_seq();
      exp_t e;
      e.word = {2'b00, ptt_in, hpf_req, lpf_req};
      e.mute = ptt_in | last_ptt;
      last_ptt = ptt_in;
      sb.push_back(e);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      repeat (2) @(negedge clock);
      k = 0;
      while ((busy || tx_inhibit) && k < budget) begin
         @(negedge clock);
         k++;
      end
      check("idle_reached", 32'({busy, tx_inhibit}), 32'd0);
   endtask

   // Main-build monitor: collects shifted bits, scores each latched word.
   initial begin
      logic p_sclk, p_strobe, p_busy, p_data;
      logic [15:0] shreg;
      int cyc, blen, sw;
      bit cur_mute;
      exp_t e;
      p_sclk = 0; p_strobe = 0; p_busy = 0; p_data = 0;
      shreg = 0; cyc = 0; blen = 0; sw = 0; cur_mute = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            shreg = 0; nbits = 0; cyc = 0; blen = 0; sw = 0;
            p_sclk = 0; p_strobe = 0; p_busy = 0; p_data = 0;
         end else begin
            if (busy) check("tx_while_busy", 32'(tx_inhibit), 32'd1);
            if (busy && !p_busy) begin
               cyc = 0; blen = 1;
            end else if (busy) begin
               cyc++; blen++;
            end
            if (!busy && p_busy)
               check("busy_len", blen,
                     (cur_mute ? MUTE : 0) + SLEN + LAT + SET);
            if (SPI_clock && !p_sclk) begin
               check("data_stable", 32'(SPI_data), 32'(p_data));
               shreg = {shreg[14:0], SPI_data};
               nbits++;
            end
            if (load_strobe && !p_strobe) begin
               strobes++;
               sw = 1;
               if (sb.size() == 0) begin
                  check("unexpected_strobe", 32'(load_strobe), 32'd0);
               end else begin
                  e = sb.pop_front();
                  cur_mute = e.mute;
                  check("word", 32'(shreg), 32'(e.word));
                  check("nbits", nbits, 16);
                  check("lead", cyc, (e.mute ? MUTE : 0) + SLEN);
                  check("lpf_active", 32'(lpf_active), 32'(e.word[6:0]));
                  check("hpf_active", 32'(hpf_active), 32'(e.word[12:7]));
               end
               nbits = 0;
               shreg = 0;
            end else if (load_strobe) begin
               sw++;
            end
            if (!load_strobe && p_strobe) check("strobe_width", sw, LAT);
            p_sclk = SPI_clock; p_strobe = load_strobe;
            p_busy = busy; p_data = SPI_data;
         end
      end
   end

   // CLK_DIV=1 monitor: per-cycle toggling, 32-cycle shift, word.
   initial begin
      logic p_sclk, p_load, p_busy, p_data;
      logic [15:0] shreg;
      int c1, n1;
      p_sclk = 0; p_load = 0; p_busy = 0; p_data = 0;
      shreg = 0; c1 = 0; n1 = 0;
      forever begin
         @(negedge clock);
         if (reset1) begin
            p_sclk = 0; p_load = 0; p_busy = 0; p_data = 0;
            shreg = 0; c1 = 0; n1 = 0;
         end else begin
            if (busy1 && !p_busy) c1 = 0;
            else if (busy1) c1++;
            if (busy1 && strobes1 == 0 && c1 >= 1 && c1 <= 31)
               check("div1_toggle", 32'(sclk1), 32'(!p_sclk));
            if (sclk1 && !p_sclk) begin
               check("div1_stable", 32'(data1), 32'(p_data));
               shreg = {shreg[14:0], data1};
               n1++;
            end
            if (load1 && !p_load) begin
               strobes1++;
               check("div1_lead", c1, 32);
               check("div1_nbits", n1, 16);
               if (sb1.size() == 0)
                  check("div1_unexpected", 32'(load1), 32'd0);
               else
                  check("div1_word", 32'(shreg), 32'(sb1.pop_front()));
            end
            p_sclk = sclk1; p_load = load1;
            p_busy = busy1; p_data = data1;
         end
      end
   end

   // CLK_DIV=1 stimulus.
   initial begin
      int k;
      reset1 = 1; lpf1 = 7'b0000101; hpf1 = 6'b100000; ptt1 = 0;
      repeat (3) @(negedge clock);
      sb1.push_back({2'b00, ptt1, hpf1, lpf1});
      reset1 = 0;
      k = 0;
      repeat (2) @(negedge clock);
      while ((busy1 || tx1) && k < 500) begin
         @(negedge clock);
         k++;
      end
      check("div1_idle", 32'({busy1, tx1}), 32'd0);
      check("div1_strobes", strobes1, 1);
      check("div1_lpf_active", 32'(lpfa1), 32'(lpf1));
      done1 = 1;
   end

   // Main stimulus.
   initial begin
      int k, s0;
      bit gap;
      reset = 1; lpf_req = 7'b0001000; hpf_req = 6'd0; ptt_in = 0;
      repeat (3) @(negedge clock);
      check("rst_SPI_data", 32'(SPI_data), 32'd0);
      check("rst_SPI_clock", 32'(SPI_clock), 32'd0);
      check("rst_load_strobe", 32'(load_strobe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_inhibit", 32'(tx_inhibit), 32'd1);
      check("rst_lpf_active", 32'(lpf_active), 32'd0);
      check("rst_hpf_active", 32'(hpf_active), 32'd0);

      expect_seq();
      reset = 0;
      wait_idle(1000);
      check("t1_lpf", 32'(lpf_active), 32'h08);

      lpf_req = 7'b0000100; expect_seq(); wait_idle(1000);
      lpf_req = 7'b0000010; expect_seq(); wait_idle(1000);
      check("t2_lpf", 32'(lpf_active), 32'h02);

      lpf_req = 7'b0000001; hpf_req = 6'b000001; ptt_in = 1;
      expect_seq(); wait_idle(1000);
      check("t3_hpf", 32'(hpf_active), 32'h01);
      ptt_in = 0; expect_seq(); wait_idle(1000);

      lpf_req = 7'b0001000; expect_seq();
      s0 = strobes;
      k = 0;
      while (!SPI_clock && k < 300) begin
         @(negedge clock);
         k++;
      end
      check("t4_shift_seen", 32'(SPI_clock), 32'd1);
      lpf_req = 7'b0010000;
      repeat (6) @(negedge clock);
      lpf_req = 7'b0100000;
      expect_seq();
      gap = 0;
      k = 0;
      while (k < 2000) begin
         @(negedge clock);
         k++;
         if (strobes >= s0 + 2 && !busy) break;
         if (!tx_inhibit) gap = 1;
      end
      check("t4_tx_gap", 32'(gap), 32'd0);
      check("t4_sequences", strobes - s0, 2);
      wait_idle(1000);
      check("t4_lpf", 32'(lpf_active), 32'h20);

      lpf_req = 7'b1000000;
      k = 0;
      while (nbits < 8 && k < 500) begin
         @(negedge clock);
         k++;
      end
      check("t5_bits_before_reset", nbits, 8);
      repeat (2) @(negedge clock);
      reset = 1;
      @(negedge clock);
      check("t5_SPI_clock", 32'(SPI_clock), 32'd0);
      check("t5_SPI_data", 32'(SPI_data), 32'd0);
      check("t5_load_strobe", 32'(load_strobe), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_tx_inhibit", 32'(tx_inhibit), 32'd1);
      check("t5_lpf_rst", 32'(lpf_active), 32'd0);
      last_ptt = 0;
      @(negedge clock);
      expect_seq();
      reset = 0;
      wait_idle(1000);
      check("t5_lpf", 32'(lpf_active), 32'h40);

      lpf_req = 7'b0000011; hpf_req = 6'b000110;
      expect_seq(); wait_idle(1000);
      check("t6_lpf", 32'(lpf_active), 32'h03);
      check("t6_hpf", 32'(hpf_active), 32'h06);

      k = 0;
      while (!done1 && k < 2000) begin
         @(negedge clock);
         k++;
      end
      check("div1_done", 32'(done1), 32'd1);
      check("sb_empty", sb.size(), 0);
      check("sb1_empty", sb1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
